// File: rtl/gshare_bht_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gshare_bht_pkg
// Brief    : Shared frontend types and helpers for the gshare direction predictor.
// Revision : 1.0 - initial release
// ============================================================================
package gshare_bht_pkg;

    // Counters are carried at the widest supported size; instances slice down.
    localparam int CTR_BITS_MAX    = 4;
    localparam int GSHARE_CTR_BITS = 2;
    localparam int GHR_W_MAX       = 16;

    typedef logic [CTR_BITS_MAX-1:0] gshare_ctr_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic                 valid;
        logic [GHR_W_MAX-1:0] ghr;
    } bht_ghr_ckpt_t;

    // Weakly not-taken value for a counter of the given width.
    function automatic gshare_ctr_t ctr_init_val(input int unsigned bits);
        return gshare_ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    localparam gshare_ctr_t CTR_INIT = ctr_init_val(GSHARE_CTR_BITS);

    function automatic gshare_ctr_t sat_update(input gshare_ctr_t ctr,
                                               input logic        taken,
                                               input int unsigned bits);
        gshare_ctr_t max_v;
        max_v = gshare_ctr_t'((1 << bits) - 1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 1'b1;
        end
        return (ctr == '0) ? '0 : ctr - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_bht.sv
`default_nettype none
// ============================================================================
// Module   : gshare_bht
// Brief    : Gshare branch direction predictor with speculative GHR and
//            init sweep of the saturating counter table.
// Revision : 1.0 - initial release
// ============================================================================
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int NR_ENTRIES = 128,
    parameter int HIST_LEN   = 3,
    parameter int CTR_BITS   = 2,
    parameter int ROW_OFF    = 1,
    parameter int VLEN       = 64,
    localparam int IDX_W     = $clog2(NR_ENTRIES),
    localparam int GHR_W     = (HIST_LEN > 0) ? HIST_LEN : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_bp_i,
    input  logic             debug_mode_i,
    output logic             ready_o,
    input  logic             req_i,
    input  logic [VLEN-1:0]  vpc_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [GHR_W-1:0] pred_ghr_o,
    input  logic             spec_valid_i,
    input  logic             spec_taken_i,
    input  logic             restore_i,
    input  logic [GHR_W-1:0] restore_ghr_i,
    input  logic             upd_valid_i,
    input  logic [VLEN-1:0]  upd_pc_i,
    input  logic [GHR_W-1:0] upd_ghr_i,
    input  logic             upd_taken_i
);

    localparam gshare_ctr_t         c_ctr_init_full = ctr_init_val(CTR_BITS);
    localparam logic [CTR_BITS-1:0] c_ctr_init      = c_ctr_init_full[CTR_BITS-1:0];
    localparam logic [IDX_W-1:0]    c_last_idx      = IDX_W'(NR_ENTRIES - 1);

    bht_state_e          r_state;
    bht_state_e          w_state_next;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_next;

    logic [CTR_BITS-1:0] r_table [NR_ENTRIES];

    logic                w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [CTR_BITS-1:0] w_wdata;

    logic [GHR_W-1:0]    w_ghr;
    logic [GHR_W-1:0]    w_upd_ghr;
    logic [IDX_W-1:0]    w_pred_idx;
    logic [IDX_W-1:0]    w_upd_idx;
    gshare_ctr_t         w_sat;
    logic                w_run;
    logic                w_unused;

    assign w_run   = (r_state == ST_RUN);
    assign ready_o = w_run;

    assign w_pred_idx = vpc_i[ROW_OFF +: IDX_W] ^ IDX_W'(w_ghr);
    assign w_upd_idx  = upd_pc_i[ROW_OFF +: IDX_W] ^ IDX_W'(w_upd_ghr);
    assign w_sat      = sat_update(gshare_ctr_t'(r_table[w_upd_idx]), upd_taken_i, CTR_BITS);

    assign w_unused = ^{vpc_i, upd_pc_i, restore_ghr_i, upd_ghr_i,
                        spec_valid_i, spec_taken_i, restore_i, w_sat};

    // ------------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------------
    generate
        if (HIST_LEN > 0) begin : g_ghr
            logic [GHR_W-1:0] r_ghr;
            logic [GHR_W:0]   w_shift_ext;

            assign w_shift_ext = {r_ghr, spec_taken_i};

            // Restore beats a speculative shift; flush beats both.
            always_ff @(posedge clk_i) begin
                if (rst_i || flush_bp_i) begin
                    r_ghr <= '0;
                end else if (w_run && !debug_mode_i) begin
                    if (restore_i) begin
                        r_ghr <= restore_ghr_i;
                    end else if (spec_valid_i) begin
                        r_ghr <= w_shift_ext[GHR_W-1:0];
                    end
                end
            end

            assign w_ghr     = r_ghr;
            assign w_upd_ghr = upd_ghr_i;
        end else begin : g_no_ghr
            assign w_ghr     = '0;
            assign w_upd_ghr = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // INIT/RUN control and the single table write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_we         = 1'b0;
        w_waddr      = r_ptr;
        w_wdata      = c_ctr_init;
        case (r_state)
            ST_INIT: begin
                w_we       = 1'b1;
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == c_last_idx) begin
                    w_state_next = ST_RUN;
                    w_ptr_next   = '0;
                end
            end
            ST_RUN: begin
                if (upd_valid_i && !debug_mode_i) begin
                    w_we    = 1'b1;
                    w_waddr = w_upd_idx;
                    w_wdata = w_sat[CTR_BITS-1:0];
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_ptr_next   = '0;
            end
        endcase
        if (flush_bp_i) begin
            w_state_next = ST_INIT;
            w_ptr_next   = '0;
            w_we         = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we && !rst_i) begin
            r_table[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Prediction register; the table read happens before this edge's write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_ghr_o   <= '0;
        end else if (req_i && w_run && !flush_bp_i) begin
            pred_valid_o <= 1'b1;
            pred_taken_o <= r_table[w_pred_idx][CTR_BITS-1];
            pred_ghr_o   <= w_ghr;
        end else begin
            pred_valid_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_bht
// Brief    : Directed self-checking bench for gshare_bht (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_bht;

    localparam logic [63:0] c_pc_a = 64'h0000_0000_8000_0010;

    logic        clk;
    logic        rst;
    logic        flush_bp;
    logic        debug_mode;
    logic        ready;
    logic        req;
    logic [63:0] vpc;
    logic        pred_valid;
    logic        pred_taken;
    logic [2:0]  pred_ghr;
    logic        spec_valid;
    logic        spec_taken;
    logic        restore;
    logic [2:0]  restore_ghr;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic [2:0]  upd_ghr;
    logic        upd_taken;

    int checks   = 0;
    int failures = 0;

    gshare_bht u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_bp_i    (flush_bp),
        .debug_mode_i  (debug_mode),
        .ready_o       (ready),
        .req_i         (req),
        .vpc_i         (vpc),
        .pred_valid_o  (pred_valid),
        .pred_taken_o  (pred_taken),
        .pred_ghr_o    (pred_ghr),
        .spec_valid_i  (spec_valid),
        .spec_taken_i  (spec_taken),
        .restore_i     (restore),
        .restore_ghr_i (restore_ghr),
        .upd_valid_i   (upd_valid),
        .upd_pc_i      (upd_pc),
        .upd_ghr_i     (upd_ghr),
        .upd_taken_i   (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic [63:0] pc);
        req = 1'b1;
        vpc = pc;
        tick();
        req = 1'b0;
    endtask

    task automatic train(input logic [63:0] pc, input logic [2:0] g, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_ghr   = g;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int  cnt;
        logic saw_valid;
        cnt       = 0;
        saw_valid = 1'b0;
        req       = 1'b1;
        vpc       = c_pc_a;
        while (!ready && cnt < 400) begin
            tick();
            cnt++;
            if (pred_valid) saw_valid = 1'b1;
        end
        req = 1'b0;
        check({tag, "_cycles"}, 32'(cnt), 32'(exp_cycles));
        check({tag, "_no_valid"}, 32'(saw_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        flush_bp    = 1'b0;
        debug_mode  = 1'b0;
        req         = 1'b0;
        vpc         = '0;
        spec_valid  = 1'b0;
        spec_taken  = 1'b0;
        restore     = 1'b0;
        restore_ghr = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_ghr     = '0;
        upd_taken   = 1'b0;

        // Reset and init sweep
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(pred_valid), 32'd0);
        check("rst_taken", 32'(pred_taken), 32'd0);
        check("rst_ghr", 32'(pred_ghr), 32'd0);
        wait_ready("init", 128);

        // Cold predict
        predict(c_pc_a);
        check("cold_valid", 32'(pred_valid), 32'd1);
        check("cold_taken", 32'(pred_taken), 32'd0);
        check("cold_ghr", 32'(pred_ghr), 32'd0);
        tick();
        check("cold_valid_drop", 32'(pred_valid), 32'd0);

        // Training: 1 -> 2 -> saturate at 3 -> down to 0 -> saturate at 0
        train(c_pc_a, 3'b000, 1'b1);
        predict(c_pc_a);
        check("train_t1", 32'(pred_taken), 32'd1);
        for (int i = 0; i < 5; i++) train(c_pc_a, 3'b000, 1'b1);
        train(c_pc_a, 3'b000, 1'b0);
        predict(c_pc_a);
        check("train_nt1", 32'(pred_taken), 32'd1);
        train(c_pc_a, 3'b000, 1'b0);
        predict(c_pc_a);
        check("train_nt2", 32'(pred_taken), 32'd0);
        train(c_pc_a, 3'b000, 1'b0);
        predict(c_pc_a);
        check("train_nt3", 32'(pred_taken), 32'd0);
        train(c_pc_a, 3'b000, 1'b0);
        train(c_pc_a, 3'b000, 1'b0);
        train(c_pc_a, 3'b000, 1'b1);
        predict(c_pc_a);
        check("sat_low", 32'(pred_taken), 32'd0);
        train(c_pc_a, 3'b000, 1'b1);
        predict(c_pc_a);
        check("sat_low_t2", 32'(pred_taken), 32'd1);

        // GHR speculative shifts; idx 8^7=15 is still weakly NT
        spec_valid = 1'b1;
        spec_taken = 1'b1;
        repeat (3) tick();
        spec_valid = 1'b0;
        predict(c_pc_a);
        check("ghr_111", 32'(pred_ghr), 32'd7);
        check("ghr_111_taken", 32'(pred_taken), 32'd0);

        restore     = 1'b1;
        restore_ghr = 3'b010;
        spec_valid  = 1'b1;
        spec_taken  = 1'b1;
        tick();
        restore    = 1'b0;
        spec_valid = 1'b0;
        predict(c_pc_a);
        check("ghr_restore", 32'(pred_ghr), 32'd2);

        spec_valid = 1'b1;
        spec_taken = 1'b0;
        tick();
        spec_valid = 1'b0;
        predict(c_pc_a);
        check("ghr_shift0", 32'(pred_ghr), 32'd4);

        // Read-before-write on a shared index (ctr idx8 = 2)
        restore     = 1'b1;
        restore_ghr = 3'b000;
        tick();
        restore = 1'b0;
        upd_valid = 1'b1;
        upd_pc    = c_pc_a;
        upd_ghr   = 3'b000;
        upd_taken = 1'b0;
        predict(c_pc_a);
        upd_valid = 1'b0;
        check("bypass_old", 32'(pred_taken), 32'd1);
        predict(c_pc_a);
        check("bypass_new", 32'(pred_taken), 32'd0);

        // Debug mode blocks training, restore and shifts (ctr idx8 = 1)
        debug_mode  = 1'b1;
        spec_valid  = 1'b1;
        spec_taken  = 1'b1;
        train(c_pc_a, 3'b000, 1'b1);
        spec_valid  = 1'b0;
        restore     = 1'b1;
        restore_ghr = 3'b101;
        train(c_pc_a, 3'b000, 1'b1);
        restore    = 1'b0;
        debug_mode = 1'b0;
        predict(c_pc_a);
        check("debug_ctr", 32'(pred_taken), 32'd0);
        check("debug_ghr", 32'(pred_ghr), 32'd0);

        // Flush: make idx8 taken and GHR nonzero, then flush and check the wipe
        train(c_pc_a, 3'b000, 1'b1);
        spec_valid = 1'b1;
        spec_taken = 1'b1;
        tick();
        spec_valid = 1'b0;
        predict(c_pc_a ^ 64'h2);
        check("preflush_taken", 32'(pred_taken), 32'd1);
        check("preflush_ghr", 32'(pred_ghr), 32'd1);

        flush_bp  = 1'b1;
        upd_valid = 1'b1;
        upd_pc    = c_pc_a;
        upd_ghr   = 3'b000;
        upd_taken = 1'b0;
        predict(c_pc_a);
        flush_bp  = 1'b0;
        upd_valid = 1'b0;
        check("flush_valid", 32'(pred_valid), 32'd0);
        check("flush_ready", 32'(ready), 32'd0);
        repeat (60) tick();
        check("flush_mid_ready", 32'(ready), 32'd0);
        flush_bp = 1'b1;
        tick();
        flush_bp = 1'b0;
        wait_ready("reflush", 128);

        predict(c_pc_a);
        check("postflush_valid", 32'(pred_valid), 32'd1);
        check("postflush_taken", 32'(pred_taken), 32'd0);
        check("postflush_ghr", 32'(pred_ghr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
